keypad_digit_entry: RTL and testbench

//  Receiving end of the keypad encoder interface: consumes the encoded digit D and the

---
 rtl/keypad_digit_entry.sv | 154 +++++++++++++++
 tb/tb_keypad_digit_entry.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_digit_entry.sv
`default_nettype none
// ============================================================================
// Module      : keypad_digit_entry
// Description : Debounces encoded keypad presses and shifts accepted digits
//               into a 4-digit BCD MM:SS entry buffer for the timer load path.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_digit_entry #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [3:0] D,
  input  logic       no_key,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] digit_cnt,
  output logic       full,
  output logic       key_strobe
);

  // Counter must hold values up to DEBOUNCE_CYCLES-1; sized from the parameter.
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] c_cnt_zero = '0;
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);
  localparam logic [CW-1:0] c_cnt_last = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    c_max_dig  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]      r_cap, w_cap_nxt;
  logic            w_accept;
  logic [3:0]      w_digit;
  logic            w_shift;

  logic [15:0]     r_buf;
  logic [2:0]      r_dcnt;
  logic            r_strobe;

  // FSM state, debounce counter and captured code registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= c_cnt_zero;
      r_cap   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cap   <= w_cap_nxt;
    end
  end

  // Next-state logic: debounce a press, accept once, then wait for a stable release.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cap_nxt   = r_cap;
    w_accept    = 1'b0;
    w_digit     = r_cap;
    if (!en) begin
      // Entry disabled: drop any press in progress so a held key restarts cleanly.
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = c_cnt_zero;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!no_key) begin
            w_cap_nxt = D;
            if (DEBOUNCE_CYCLES <= 1) begin
              // Single-cycle debounce: the first sampled press is already stable.
              w_accept    = 1'b1;
              w_digit     = D;
              w_state_nxt = S_HELD;
              w_cnt_nxt   = c_cnt_zero;
            end else begin
              w_state_nxt = S_DEBOUNCE;
              w_cnt_nxt   = c_cnt_one;
            end
          end
        end
        S_DEBOUNCE: begin
          if (no_key || (D != r_cap)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = c_cnt_zero;
          end else if (r_cnt >= c_cnt_last) begin
            w_accept    = 1'b1;
            w_state_nxt = S_HELD;
            w_cnt_nxt   = c_cnt_zero;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
        S_HELD: begin
          if (!no_key) begin
            // Any bounce or code change while held restarts the release count.
            w_cnt_nxt = c_cnt_zero;
          end else if (r_cnt >= c_cnt_last) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = c_cnt_zero;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = c_cnt_zero;
        end
      endcase
    end
  end

  // An accepted digit enters the buffer unless it is full or a leading zero.
  assign w_shift = w_accept && (r_dcnt != c_max_dig) &&
                   !((w_digit == 4'd0) && (r_dcnt == 3'd0));

  // Entry buffer, digit count and strobe; clear overrides a same-edge accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf    <= 16'd0;
      r_dcnt   <= 3'd0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (clr) begin
        r_buf  <= 16'd0;
        r_dcnt <= 3'd0;
      end else if (w_shift) begin
        r_buf    <= {r_buf[11:0], w_digit};
        r_dcnt   <= r_dcnt + 3'd1;
        r_strobe <= 1'b1;
      end
    end
  end

  assign min_tens   = r_buf[15:12];
  assign min_ones   = r_buf[11:8];
  assign sec_tens   = r_buf[7:4];
  assign sec_ones   = r_buf[3:0];
  assign digit_cnt  = r_dcnt;
  assign full       = (r_dcnt == c_max_dig);
  assign key_strobe = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_keypad_digit_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_digit_entry
// Description : Directed self-checking bench for keypad_digit_entry with a
//               strobe scoreboard fed by a reference entry model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_digit_entry;

  logic       clk = 1'b0;
  logic       rst, en, clr, no_key;
  logic [3:0] D;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [2:0] digit_cnt;
  logic       full, key_strobe;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_strobe = 0;
  int last_strobe_cyc = 0;
  int press_cyc = 0;
  int s0 = 0;

  logic [15:0] m_buf = 16'd0;
  logic [2:0]  m_cnt = 3'd0;
  logic [31:0] sbq[$];

  keypad_digit_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .D(D), .no_key(no_key),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .digit_cnt(digit_cnt), .full(full),
    .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  // Edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dut_state();
    return {13'd0, min_tens, min_ones, sec_tens, sec_ones, digit_cnt};
  endfunction

  function automatic logic [31:0] model_state();
    return {13'd0, m_buf, m_cnt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference entry rule: predicts the buffer after a debounced press.
  task automatic expect_digit(input logic [3:0] d);
    if (m_cnt < 3'd4 && !(d == 4'd0 && m_cnt == 3'd0)) begin
      m_buf = {m_buf[11:0], d};
      m_cnt = m_cnt + 3'd1;
      sbq.push_back(model_state());
    end
  endtask

  task automatic model_clear();
    m_buf = 16'd0;
    m_cnt = 3'd0;
  endtask

  task automatic press(input logic [3:0] d, input int hold);
    D = d;
    no_key = 1'b0;
    tick(hold);
    no_key = 1'b1;
    tick(6);
  endtask

  // Scoreboard consumer: every strobe must match the oldest predicted buffer.
  always @(negedge clk) begin
    if (key_strobe === 1'b1) begin
      n_strobe++;
      last_strobe_cyc = cyc;
      if (sbq.size() == 0) begin
        chk("unexpected_strobe", {31'd0, key_strobe}, 32'd0);
      end else begin
        chk("strobe_buf", dut_state(), sbq.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0; D = 4'd0; no_key = 1'b1;
    tick(2);
    chk("rst_buf", dut_state(), 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_strobe", {31'd0, key_strobe}, 32'd0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_buf", dut_state(), 32'd0);

    // Single clean press of 5 held 10 cycles.
    s0 = n_strobe;
    expect_digit(4'd5);
    D = 4'd5; no_key = 1'b0; press_cyc = cyc;
    tick(10);
    no_key = 1'b1;
    tick(6);
    chk("t2_strobes", n_strobe - s0, 1);
    chk("t2_latency", last_strobe_cyc - press_cyc, 4);
    chk("t2_buf", dut_state(), model_state());

    // Short glitch and a code change during debounce: nothing accepted.
    s0 = n_strobe;
    D = 4'd1; no_key = 1'b0; tick(2);
    no_key = 1'b1; tick(3);
    D = 4'd3; no_key = 1'b0; tick(2);
    D = 4'd4; tick(1);
    no_key = 1'b1; tick(6);
    chk("t3_strobes", n_strobe - s0, 0);
    chk("t3_buf", dut_state(), model_state());

    clr = 1'b1; tick(1); clr = 1'b0; model_clear();
    chk("clr_buf", dut_state(), 32'd0);

    // Fill to 12:34; the fifth digit is discarded.
    s0 = n_strobe;
    for (int i = 1; i <= 5; i++) begin
      expect_digit(4'(i));
      press(4'(i), 6);
    end
    chk("t4_buf", dut_state(), {13'd0, 16'h1234, 3'd4});
    chk("t4_full", {31'd0, full}, 32'd1);
    chk("t4_strobes", n_strobe - s0, 4);

    clr = 1'b1; tick(1); clr = 1'b0; model_clear();
    chk("t4_clr_full", {31'd0, full}, 32'd0);

    // Leading zero dropped; zero after a non-zero digit kept.
    s0 = n_strobe;
    expect_digit(4'd0); press(4'd0, 6);
    chk("t5_lead0_cnt", {29'd0, digit_cnt}, 32'd0);
    chk("t5_lead0_strobes", n_strobe - s0, 0);
    expect_digit(4'd7); press(4'd7, 6);
    expect_digit(4'd0); press(4'd0, 6);
    chk("t5_buf", dut_state(), {13'd0, 16'h0070, 3'd2});

    // Clear on the accept edge: digit dropped, held key not re-accepted.
    s0 = n_strobe;
    D = 4'd9; no_key = 1'b0; tick(3);
    clr = 1'b1; tick(1); clr = 1'b0;
    model_clear();
    tick(4);
    no_key = 1'b1; tick(6);
    chk("t6_clr_buf", dut_state(), 32'd0);
    chk("t6_clr_strobes", n_strobe - s0, 0);

    // Disabled entry ignores a held key; raising en treats it as a fresh press.
    s0 = n_strobe;
    en = 1'b0; D = 4'd2; no_key = 1'b0; tick(6);
    chk("en_low_strobes", n_strobe - s0, 0);
    expect_digit(4'd2);
    en = 1'b1; tick(6);
    no_key = 1'b1; tick(6);
    chk("en_rise_strobes", n_strobe - s0, 1);
    chk("en_rise_buf", dut_state(), model_state());

    // Reset in the middle of a debounce.
    expect_digit(4'd6); press(4'd6, 6);
    D = 4'd3; no_key = 1'b0; tick(2);
    rst = 1'b1; no_key = 1'b1; tick(1);
    rst = 1'b0; model_clear();
    chk("t6_rst_buf", dut_state(), 32'd0);
    chk("t6_rst_strobe", {31'd0, key_strobe}, 32'd0);
    tick(6);
    s0 = n_strobe;
    expect_digit(4'd8); press(4'd8, 6);
    chk("post_rst_strobes", n_strobe - s0, 1);
    chk("post_rst_buf", dut_state(), {13'd0, 16'h0008, 3'd1});

    chk("sb_drained", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
